// File: rtl/axi4_master_txn_monitor.sv
// Passive AXI4 master-port monitor: outstanding burst tracking, WLAST/RLAST
// placement checks, orphan response detection and saturating counters.
// Optional read-latency measurement is enabled by defining AXI4_MON_LATENCY_EN.

// Small synchronous FIFO with occupancy count; a push while full is accepted
// only when a pop happens in the same cycle.
module axi4_mon_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] P_ONE = 1;
  localparam logic [CW-1:0] C_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_do_pop  = pop & ~w_empty;
  assign w_do_push = push & (~w_full | w_do_pop);
  assign dout      = r_mem[r_rp];
  assign count     = r_cnt;

  // Storage write; contents need no reset since the count gates their use.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp] <= din;
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + P_ONE;
      if (w_do_pop)  r_rp <= r_rp + P_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + C_ONE;
        2'b01:   r_cnt <= r_cnt - C_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module axi4_master_txn_monitor #(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_WIDTH       = 32,
  parameter int unsigned LAT_WIDTH       = 16,
  localparam int unsigned OW             = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 err_clr,
  input  logic                 awvalid,
  input  logic                 awready,
  input  logic [7:0]           awlen,
  input  logic                 wvalid,
  input  logic                 wready,
  input  logic                 wlast,
  input  logic                 bvalid,
  input  logic                 bready,
  input  logic [1:0]           bresp,
  input  logic                 arvalid,
  input  logic                 arready,
  input  logic [7:0]           arlen,
  input  logic                 rvalid,
  input  logic                 rready,
  input  logic                 rlast,
  input  logic [1:0]           rresp,
  output logic [OW-1:0]        wr_outstanding,
  output logic [OW-1:0]        rd_outstanding,
  output logic [CNT_WIDTH-1:0] wr_done_cnt,
  output logic [CNT_WIDTH-1:0] rd_done_cnt,
  output logic [CNT_WIDTH-1:0] resp_err_cnt,
  output logic [4:0]           err_flags,
  output logic [LAT_WIDTH-1:0] rd_lat_last,
  output logic [LAT_WIDTH-1:0] rd_lat_max
);
`ifdef AXI4_MON_LATENCY_EN
  localparam int unsigned ARW = 8 + LAT_WIDTH;
`else
  localparam int unsigned ARW = 8;
`endif
  localparam logic [OW-1:0] O_ONE = 1;

  function automatic logic [CNT_WIDTH-1:0] f_sat_add(input logic [CNT_WIDTH-1:0] v,
                                                     input logic [1:0] n);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, v} + {{(CNT_WIDTH-1){1'b0}}, n};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  assign w_aw_hs = awvalid & awready;
  assign w_w_hs  = wvalid & wready;
  assign w_b_hs  = bvalid & bready;
  assign w_ar_hs = arvalid & arready;
  assign w_r_hs  = rvalid & rready;

  logic [OW-1:0]        r_wr_out;
  logic [CNT_WIDTH-1:0] r_wr_done, r_rd_done, r_resp_err;
  logic [4:0]           r_err;
  logic [7:0]           r_wbeats;
  logic [7:0]           r_ridx;

  // Write side: AW lengths and observed W burst lengths paired in order.
  logic [7:0]    w_awf_head, w_wf_head;
  logic [OW-1:0] w_awf_cnt, w_wf_cnt;
  logic          w_pair, w_aw_ovf, w_wlen_err;

  assign w_pair     = (w_awf_cnt != '0) & (w_wf_cnt != '0);
  assign w_aw_ovf   = w_aw_hs & (w_awf_cnt == OW'(MAX_OUTSTANDING)) & ~w_pair;
  assign w_wlen_err = w_pair & (w_awf_head != w_wf_head);

  axi4_mon_fifo #(.WIDTH(8), .DEPTH(MAX_OUTSTANDING)) u_aw_fifo (
    .clk(aclk), .rst(areset), .push(w_aw_hs), .pop(w_pair),
    .din(awlen), .dout(w_awf_head), .count(w_awf_cnt)
  );

  axi4_mon_fifo #(.WIDTH(8), .DEPTH(MAX_OUTSTANDING)) u_w_fifo (
    .clk(aclk), .rst(areset), .push(w_w_hs & wlast), .pop(w_pair),
    .din(r_wbeats), .dout(w_wf_head), .count(w_wf_cnt)
  );

  // Read side: AR entries consumed by RLAST, beat index checked against length.
  logic [ARW-1:0] w_ar_din, w_ar_head;
  logic [OW-1:0]  w_ar_cnt;
  logic           w_ar_empty, w_r_ok, w_ar_pop, w_ar_ovf, w_rlast_err, w_r_orphan;

  assign w_ar_empty  = (w_ar_cnt == '0);
  assign w_r_ok      = w_r_hs & ~w_ar_empty;
  assign w_r_orphan  = w_r_hs & w_ar_empty;
  assign w_ar_pop    = w_r_ok & rlast;
  assign w_ar_ovf    = w_ar_hs & (w_ar_cnt == OW'(MAX_OUTSTANDING)) & ~w_ar_pop;
  assign w_rlast_err = w_r_ok & (rlast != (r_ridx == w_ar_head[7:0]));

  axi4_mon_fifo #(.WIDTH(ARW), .DEPTH(MAX_OUTSTANDING)) u_ar_fifo (
    .clk(aclk), .rst(areset), .push(w_ar_hs), .pop(w_ar_pop),
    .din(w_ar_din), .dout(w_ar_head), .count(w_ar_cnt)
  );

  // B accounting uses the registered (pre-cycle) outstanding count.
  logic       w_b_orphan, w_wr_inc, w_wr_dec;
  logic [1:0] w_err_inc;
  logic [4:0] w_new_err;

  assign w_b_orphan = w_b_hs & (r_wr_out == '0);
  assign w_wr_inc   = w_aw_hs & ~w_aw_ovf;
  assign w_wr_dec   = w_b_hs & ~w_b_orphan;
  assign w_err_inc  = {1'b0, w_b_hs & bresp[1]} + {1'b0, w_r_hs & rresp[1]};
  assign w_new_err  = {w_aw_ovf | w_ar_ovf, w_r_orphan, w_b_orphan, w_rlast_err, w_wlen_err};

  // Beat counters for the W and R channels.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wbeats <= '0;
      r_ridx   <= '0;
    end else begin
      if (w_w_hs) r_wbeats <= wlast ? '0 : r_wbeats + 8'd1;
      if (w_r_ok) r_ridx   <= rlast ? '0 : r_ridx + 8'd1;
    end
  end

  // Outstanding-write count, saturating completion/error counters, sticky flags.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_out   <= '0;
      r_wr_done  <= '0;
      r_rd_done  <= '0;
      r_resp_err <= '0;
      r_err      <= '0;
    end else begin
      case ({w_wr_inc, w_wr_dec})
        2'b10:   if (r_wr_out != '1) r_wr_out <= r_wr_out + O_ONE;
        2'b01:   r_wr_out <= r_wr_out - O_ONE;
        default: r_wr_out <= r_wr_out;
      endcase
      r_wr_done  <= f_sat_add(r_wr_done, {1'b0, w_wr_dec});
      r_rd_done  <= f_sat_add(r_rd_done, {1'b0, w_ar_pop});
      r_resp_err <= f_sat_add(r_resp_err, w_err_inc);
      // New errors are OR-ed after the clear so a same-cycle error survives it.
      r_err      <= (err_clr ? 5'b0 : r_err) | w_new_err;
    end
  end

`ifdef AXI4_MON_LATENCY_EN
  localparam logic [LAT_WIDTH-1:0] L_ONE = 1;
  logic [LAT_WIDTH-1:0] r_ts, r_lat_last, r_lat_max, w_lat;

  assign w_ar_din = {r_ts, arlen};
  assign w_lat    = r_ts - w_ar_head[8 +: LAT_WIDTH];

  // Free-running timestamp and latency capture on each RLAST pop.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_ts       <= '0;
      r_lat_last <= '0;
      r_lat_max  <= '0;
    end else begin
      r_ts <= r_ts + L_ONE;
      if (w_ar_pop) begin
        r_lat_last <= w_lat;
        if (w_lat > r_lat_max) r_lat_max <= w_lat;
      end
    end
  end

  assign rd_lat_last = r_lat_last;
  assign rd_lat_max  = r_lat_max;
`else
  assign w_ar_din    = arlen;
  assign rd_lat_last = '0;
  assign rd_lat_max  = '0;
`endif

  assign wr_outstanding = r_wr_out;
  assign rd_outstanding = w_ar_cnt;
  assign wr_done_cnt    = r_wr_done;
  assign rd_done_cnt    = r_rd_done;
  assign resp_err_cnt   = r_resp_err;
  assign err_flags      = r_err;
endmodule

// File: tb/tb_axi4_master_txn_monitor.sv
// Self-checking bench for axi4_master_txn_monitor: directed scenarios followed
// by random traffic compared against a queue-based reference model.
module tb_axi4_master_txn_monitor;
  localparam int N     = 8;
  localparam int CW    = 10;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int OMAX  = 15;
  localparam int LMASK = 16'hFFFF;

  logic aclk = 1'b0;
  logic areset, err_clr;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast;
  logic [7:0] awlen, arlen;
  logic [1:0] bresp, rresp;
  logic [3:0] wr_outstanding, rd_outstanding;
  logic [CW-1:0] wr_done_cnt, rd_done_cnt, resp_err_cnt;
  logic [4:0] err_flags;
  logic [15:0] rd_lat_last, rd_lat_max;

  axi4_master_txn_monitor #(.MAX_OUTSTANDING(N), .CNT_WIDTH(CW), .LAT_WIDTH(16)) dut (
    .aclk(aclk), .areset(areset), .err_clr(err_clr),
    .awvalid(awvalid), .awready(awready), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt),
    .resp_err_cnt(resp_err_cnt), .err_flags(err_flags),
    .rd_lat_last(rd_lat_last), .rd_lat_max(rd_lat_max)
  );

  always #5 aclk = ~aclk;

  // Reference model state
  typedef struct { int len; int ts; } ar_t;
  int   aw_q[$];
  int   wq[$];
  ar_t  ar_q[$];
  int   m_wr_out, m_wr_done, m_rd_done, m_err_cnt, m_wbeats, m_ridx, m_cyc;
  int   m_lat_last, m_lat_max;
  logic [4:0] m_flags;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    areset = 0; err_clr = 0;
    awvalid = 0; awready = 0; awlen = 0;
    wvalid = 0; wready = 0; wlast = 0;
    bvalid = 0; bready = 0; bresp = 0;
    arvalid = 0; arready = 0; arlen = 0;
    rvalid = 0; rready = 0; rlast = 0; rresp = 0;
  endtask

  task automatic check_all();
    chk("wr_outstanding", wr_outstanding, m_wr_out);
    chk("rd_outstanding", rd_outstanding, ar_q.size());
    chk("wr_done_cnt", wr_done_cnt, m_wr_done);
    chk("rd_done_cnt", rd_done_cnt, m_rd_done);
    chk("resp_err_cnt", resp_err_cnt, m_err_cnt);
    chk("err_flags", err_flags, m_flags);
`ifdef AXI4_MON_LATENCY_EN
    chk("rd_lat_last", rd_lat_last, m_lat_last);
    chk("rd_lat_max", rd_lat_max, m_lat_max);
`else
    chk("rd_lat_last", rd_lat_last, 0);
    chk("rd_lat_max", rd_lat_max, 0);
`endif
  endtask

  // Advance the model by the current inputs, clock once, compare everything.
  task automatic tick();
    logic [4:0] nf;
    int pre, e_inc, lat;
    bit orphan, inc, dec;
    if (areset) begin
      aw_q.delete(); wq.delete(); ar_q.delete();
      m_wr_out = 0; m_wr_done = 0; m_rd_done = 0; m_err_cnt = 0;
      m_wbeats = 0; m_ridx = 0; m_cyc = 0; m_lat_last = 0; m_lat_max = 0;
      m_flags = 0;
    end else begin
      nf = 0; e_inc = 0;
      if (aw_q.size() > 0 && wq.size() > 0) begin
        if (aw_q[0] != wq[0]) nf[0] = 1;
        void'(aw_q.pop_front());
        void'(wq.pop_front());
      end
      inc = 0;
      if (awvalid && awready) begin
        if (aw_q.size() == N) nf[4] = 1;
        else begin aw_q.push_back(int'(awlen)); inc = 1; end
      end
      if (wvalid && wready) begin
        if (wlast) begin
          if (wq.size() < N) wq.push_back(m_wbeats);
          m_wbeats = 0;
        end else m_wbeats = (m_wbeats + 1) & 255;
      end
      pre = m_wr_out; orphan = 0; dec = 0;
      if (bvalid && bready) begin
        if (bresp[1]) e_inc++;
        if (pre == 0) begin orphan = 1; nf[2] = 1; end
        else begin dec = 1; m_wr_done = (m_wr_done + 1 > CMAX) ? CMAX : m_wr_done + 1; end
      end
      m_wr_out = pre + int'(inc) - int'(dec);
      if (m_wr_out > OMAX) m_wr_out = OMAX;
      if (rvalid && rready) begin
        if (rresp[1]) e_inc++;
        if (ar_q.size() == 0) nf[3] = 1;
        else begin
          if (rlast != (m_ridx == ar_q[0].len)) nf[1] = 1;
          if (rlast) begin
            lat = (m_cyc - ar_q[0].ts) & LMASK;
            m_lat_last = lat;
            if (lat > m_lat_max) m_lat_max = lat;
            void'(ar_q.pop_front());
            m_ridx = 0;
            m_rd_done = (m_rd_done + 1 > CMAX) ? CMAX : m_rd_done + 1;
          end else m_ridx = (m_ridx + 1) & 255;
        end
      end
      if (arvalid && arready) begin
        if (ar_q.size() == N) nf[4] = 1;
        else ar_q.push_back('{len: int'(arlen), ts: m_cyc});
      end
      m_err_cnt = (m_err_cnt + e_inc > CMAX) ? CMAX : m_err_cnt + e_inc;
      m_flags = (err_clr ? 5'b0 : m_flags) | nf;
      m_cyc++;
    end
    @(posedge aclk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    idle(); areset = 1; tick(); idle();
  endtask

  task automatic aw(input int len);
    idle(); awvalid = 1; awready = 1; awlen = 8'(len); tick(); idle();
  endtask
  task automatic ar(input int len);
    idle(); arvalid = 1; arready = 1; arlen = 8'(len); tick(); idle();
  endtask
  task automatic wbeat(input bit last);
    idle(); wvalid = 1; wready = 1; wlast = last; tick(); idle();
  endtask
  task automatic rbeat(input bit last);
    idle(); rvalid = 1; rready = 1; rlast = last; tick(); idle();
  endtask
  task automatic bresp_hs();
    idle(); bvalid = 1; bready = 1; tick(); idle();
  endtask

  initial begin
    idle();
    do_reset();
    chk("reset_wr_out", wr_outstanding, 0);
    chk("reset_flags", err_flags, 0);

    // Basic write: AW then data then B
    aw(3);
    chk("t1_wr_out_1", wr_outstanding, 1);
    for (int i = 0; i < 4; i++) wbeat(i == 3);
    tick();
    bresp_hs();
    chk("t1_wr_done", wr_done_cnt, 1);
    chk("t1_wr_out_0", wr_outstanding, 0);
    chk("t1_flags", err_flags, 0);

    // Write data leading its address
    do_reset();
    for (int i = 0; i < 4; i++) wbeat(i == 3);
    aw(3);
    tick();
    bresp_hs();
    chk("t2_wr_done", wr_done_cnt, 1);
    chk("t2_flags", err_flags, 0);

    // Early RLAST, then clear
    do_reset();
    ar(7);
    for (int i = 0; i < 6; i++) rbeat(i == 5);
    chk("t3_flags", err_flags, 5'b00010);
    chk("t3_rd_done", rd_done_cnt, 1);
    idle(); err_clr = 1; tick(); idle();
    chk("t3_clr_flags", err_flags, 0);
    chk("t3_clr_rd_done", rd_done_cnt, 1);

    // Fill AR, push+pop while full, overflow, orphan B
    do_reset();
    for (int i = 0; i < 8; i++) ar(0);
    chk("t4_full", rd_outstanding, 8);
    idle(); arvalid = 1; arready = 1; rvalid = 1; rready = 1; rlast = 1; tick(); idle();
    chk("t4_pushpop_out", rd_outstanding, 8);
    chk("t4_pushpop_flags", err_flags, 0);
    ar(0);
    chk("t4_ovf_out", rd_outstanding, 8);
    chk("t4_ovf_flags", err_flags, 5'b10000);
    bresp_hs();
    chk("t4_borphan_flags", err_flags, 5'b10100);
    chk("t4_wr_out", wr_outstanding, 0);

    // Read latency
    do_reset();
    ar(0);
    repeat (11) tick();
    rbeat(1);
    ar(0);
    repeat (4) tick();
    rbeat(1);
`ifdef AXI4_MON_LATENCY_EN
    chk("t5_lat_last", rd_lat_last, 5);
    chk("t5_lat_max", rd_lat_max, 12);
`else
    chk("t5_lat_last", rd_lat_last, 0);
    chk("t5_lat_max", rd_lat_max, 0);
`endif

    // Reset in the middle of a read burst
    do_reset();
    ar(7);
    rbeat(0); rbeat(0);
    do_reset();
    chk("t6_rd_out", rd_outstanding, 0);
    chk("t6_rd_done", rd_done_cnt, 0);
    chk("t6_flags", err_flags, 0);
    chk("t6_wr_out", wr_outstanding, 0);
    ar(0);
    rbeat(1);
    chk("t6_rd_done_1", rd_done_cnt, 1);
    chk("t6_flags_1", err_flags, 0);

    // Counter saturation
    do_reset();
    idle(); arvalid = 1; arready = 1; rvalid = 1; rready = 1; rlast = 1; rresp = 2'b10;
    repeat (CMAX + 8) tick();
    idle();
    chk("sat_rd_done", rd_done_cnt, CMAX);
    chk("sat_resp_err", resp_err_cnt, CMAX);
    chk("sat_flags", err_flags, 5'b01000);

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      areset  = ($urandom_range(0, 299) == 0);
      err_clr = ($urandom_range(0, 31) == 0);
      awvalid = $urandom_range(0, 1); awready = $urandom_range(0, 1);
      awlen   = 8'($urandom_range(0, 3));
      wvalid  = $urandom_range(0, 1); wready = $urandom_range(0, 1);
      wlast   = ($urandom_range(0, 3) == 0);
      bvalid  = ($urandom_range(0, 3) == 0); bready = $urandom_range(0, 1);
      bresp   = 2'($urandom_range(0, 3));
      arvalid = $urandom_range(0, 1); arready = $urandom_range(0, 1);
      arlen   = 8'($urandom_range(0, 3));
      rvalid  = $urandom_range(0, 1); rready = $urandom_range(0, 1);
      if (ar_q.size() > 0 && $urandom_range(0, 9) != 0) rlast = (m_ridx == ar_q[0].len);
      else rlast = $urandom_range(0, 1);
      rresp   = 2'($urandom_range(0, 3));
      tick();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
